mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Initiator for the shared 16-bit memory bus used by memory256x16 / memory256x16_program chips.
- Accepts burst read and burst write commands on a valid/ready front end.
- Decodes chip enables from the address high byte, drives address and control, and drives or releases the tristate data bus.
- Returns read words on a registered valid strobe; sits between the datapath/controller and the memory chips.

Parameters:
NUM_CHIPS, 4, number of 256-word chips on the bus; legal range 1..256; chip i serves word addresses i*256..i*256+255.

Ports:
clock  input  1  system clock, rising edge
reset_L  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  master can accept a command
cmd_write  input  1  1 = burst write, 0 = burst read
cmd_addr  input  16  first word address
cmd_len  input  8  burst length minus one (0 = 1 word, 255 = 256 words)
wdata  input  16  write word
wvalid  input  1  wdata valid
wready  output  1  master can take a write word
rdata  output  16  read word
rvalid  output  1  rdata valid, one-cycle pulse per word
done  output  1  one-cycle pulse when the burst completes
err  output  1  sticky: burst touched an unmapped address
mem_data  inout  16  shared tristate data bus
mem_addr  output  8  word address within chip
mem_en  output  NUM_CHIPS  one-hot chip enable
mem_we_L  output  wr_cond_code_t  write strobe, MEM_WR when writing
mem_re_L  output  rd_cond_code_t  read strobe, MEM_RD when reading

Behaviour:
- Reset: clock and reset_L as decided: reset_L asynchronous, active-low; clock clock.
- On reset assertion (asynchronous): state=IDLE, cmd_ready=1, wready=0, rdata=0, rvalid=0, done=0, err=0, mem_en=0, mem_addr=0.
- Also on reset: mem_we_L and mem_re_L at their non-asserted enum values, mem_data released (z).
- Reset mid-burst aborts the burst immediately; the bus is released and no partial done pulse is produced.
- States: IDLE, RD, WR, DONE.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready at a posedge:
  - capture addr_q=cmd_addr and cnt_q=cmd_len, clear err;
  - go to WR if cmd_write, else RD.
- Bus outputs are combinational from registered state. mem_addr=addr_q[7:0].
- mem_en[addr_q[15:8]]=1 only in RD, or in WR with wvalid, and only when addr_q[15:8] < NUM_CHIPS; otherwise mem_en=0.
- RD: mem_re_L=MEM_RD every cycle; mem_data never driven.
  - At each posedge: rdata <= mem_data (or 16'h0000 if unmapped, and err <= 1); rvalid <= 1 in the next cycle.
  - addr_q increments; if cnt_q==0 go to DONE, else cnt_q decrements.
  - Throughput is one word per cycle; rvalid follows each read cycle by exactly one cycle; there is no read backpressure.
- WR: wready=1.
  - When wvalid=1: mem_data is driven with wdata and mem_we_L=MEM_WR; the chip captures the word at that posedge.
  - addr_q and cnt_q then advance as in RD; the last word goes to DONE.
  - When wvalid=0: mem_we_L is non-asserted, mem_en=0, mem_data is released, and the address is held (stall of any length).
  - An unmapped write still consumes the word and sets err; no chip is enabled.
- DONE: done=1 for exactly one cycle, cmd_ready=0, bus idle; next state IDLE. A new command can be accepted one cycle after done.
- Outside WR-with-wvalid, mem_data is always z; the master never drives the bus while mem_re_L=MEM_RD.
- Address wraps 16'hFFFF -> 16'h0000. A chip-boundary crossing within a burst switches mem_en on the next word with no bubble.
- err stays set after DONE until the next command is accepted.
- cmd_len=255 gives 256 words; cnt_q is 8 bits and never underflows.

Test Plan:
- Write 1 word (len 0, addr 16'h0010, wdata 16'hBEEF), then read it back -> mem_en=4'b0001, mem_addr=8'h10, rdata=16'hBEEF with rvalid one cycle after the read cycle, done after each burst, err=0.
- Read burst len 3 at 16'h00FE over preloaded memory -> mem_en goes 0001,0001,0010,0010; mem_addr FE,FF,00,01; 4 consecutive rvalid pulses then done.
- Write burst len 2 at 16'h0120 with wvalid low for 2 cycles between words -> we asserted only in wvalid cycles, mem_data z during stalls, later readback of 3 words matches.
- NUM_CHIPS=4, read at 16'h0500 -> mem_en=0, rdata=16'h0000, err=1 after DONE and still 1 until the next accept clears it.
- NUM_CHIPS=256, read len 1 at 16'hFFFF -> addresses FFFF then 0000; mem_en bit 255 then bit 0.
- Assert reset_L low mid-write-burst -> all outputs return to reset values in the same cycle, mem_data z, no done pulse; a subsequent command runs normally.

Source files
------------

// File: rtl/mem_bus_master.sv
// Burst initiator for the shared 16-bit memory bus: a valid/ready command front end,
// one-hot chip decode from the address high byte, and a tristate data bus.
package mem_bus_pkg;
  typedef enum logic { MEM_WR = 1'b0, MEM_WR_OFF = 1'b1 } wr_cond_code_t;
  typedef enum logic { MEM_RD = 1'b0, MEM_RD_OFF = 1'b1 } rd_cond_code_t;
endpackage

module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int NUM_CHIPS = 4
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [15:0]          cmd_addr,
  input  logic [7:0]           cmd_len,
  input  logic [15:0]          wdata,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [15:0]          rdata,
  output logic                 rvalid,
  output logic                 done,
  output logic                 err,
  inout  wire  [15:0]          mem_data,
  output logic [7:0]           mem_addr,
  output logic [NUM_CHIPS-1:0] mem_en,
  output wr_cond_code_t        mem_we_L,
  output rd_cond_code_t        mem_re_L
);

  typedef enum logic [1:0] { IDLE, RD, WR, DONE } state_t;

  state_t      state, state_d;
  logic [15:0] addr_q;
  logic [7:0]  cnt_q;
  logic        mapped;
  logic        wr_beat;
  logic        beat;
  logic        accept;

  // Nine bits so the compare still works when NUM_CHIPS is 256.
  assign mapped  = {1'b0, addr_q[15:8]} < 9'(NUM_CHIPS);
  assign wr_beat = (state == WR) && wvalid;
  assign beat    = (state == RD) || wr_beat;
  assign accept  = (state == IDLE) && cmd_valid;

  assign mem_data = wr_beat ? wdata : 'z;

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no branch can leave one unassigned and infer a latch.
    state_d   = state;
    cmd_ready = 1'b0;
    wready    = 1'b0;
    done      = 1'b0;
    mem_en    = '0;
    mem_we_L  = MEM_WR_OFF;
    mem_re_L  = MEM_RD_OFF;
    mem_addr  = addr_q[7:0];
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_write ? WR : RD;
      end
      RD: begin
        mem_re_L = MEM_RD;
        if (cnt_q == 8'd0) state_d = DONE;
      end
      WR: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we_L = MEM_WR;
          if (cnt_q == 8'd0) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (beat && mapped) mem_en = NUM_CHIPS'(1) << addr_q[15:8];
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      addr_q <= 16'h0000;
      cnt_q  <= 8'd0;
      rdata  <= 16'h0000;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rvalid <= (state == RD);
      if (state == RD) rdata <= mapped ? mem_data : 16'h0000;
      if (accept) begin
        addr_q <= cmd_addr;
        cnt_q  <= cmd_len;
        err    <= 1'b0;
      end else if (beat) begin
        // Address wraps naturally at 16'hFFFF; the count stops at zero on the last word.
        addr_q <= addr_q + 16'd1;
        if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        if (!mapped) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a 4-chip instance against a bus memory and a transfer-level
// model, plus a 256-chip instance for the address-wrap decode.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam logic [15:0] SENTINEL = 16'h5AA5;

  logic clock = 1'b0;
  logic reset_L = 1'b0;
  always #5 clock = ~clock;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0, wvalid = 1'b0;
  logic [15:0] cmd_addr = 16'h0, wdata = 16'h0;
  logic [7:0]  cmd_len = 8'h0;
  logic        cmd_ready, wready, rvalid, done, err;
  logic [15:0] rdata;
  wire  [15:0] mem_data;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_en;
  wr_cond_code_t mem_we_L;
  rd_cond_code_t mem_re_L;

  logic        cmd_valid2 = 1'b0, cmd_write2 = 1'b0, wvalid2 = 1'b0;
  logic [15:0] cmd_addr2 = 16'h0, wdata2 = 16'h0;
  logic [7:0]  cmd_len2 = 8'h0;
  logic        cmd_ready2, wready2, rvalid2, done2, err2;
  logic [15:0] rdata2;
  wire  [15:0] mem_data2;
  logic [7:0]  mem_addr2;
  logic [255:0] mem_en2;
  wr_cond_code_t mem_we_L2;
  rd_cond_code_t mem_re_L2;

  mem_bus_master #(.NUM_CHIPS(4)) dut (
    .clock(clock), .reset_L(reset_L), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata),
    .wvalid(wvalid), .wready(wready), .rdata(rdata), .rvalid(rvalid), .done(done),
    .err(err), .mem_data(mem_data), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_we_L(mem_we_L), .mem_re_L(mem_re_L));

  mem_bus_master #(.NUM_CHIPS(256)) dut256 (
    .clock(clock), .reset_L(reset_L), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_write(cmd_write2), .cmd_addr(cmd_addr2), .cmd_len(cmd_len2), .wdata(wdata2),
    .wvalid(wvalid2), .wready(wready2), .rdata(rdata2), .rvalid(rvalid2), .done(done2),
    .err(err2), .mem_data(mem_data2), .mem_addr(mem_addr2), .mem_en(mem_en2),
    .mem_we_L(mem_we_L2), .mem_re_L(mem_re_L2));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Bus-side chips: the memory answers enabled reads, and a keeper drives SENTINEL
  // whenever nobody else should be on the bus.
  logic [15:0] dev_mem [0:1023];
  logic [15:0] ref_mem [0:1023];

  function automatic int chip_of4(input logic [3:0] en);
    for (int i = 0; i < 4; i++) if (en[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] chip_of256(input logic [255:0] en);
    for (int i = 0; i < 256; i++) if (en[i]) return 8'(i);
    return 8'h00;
  endfunction

  assign mem_data = (mem_re_L == MEM_RD && mem_en != 4'b0) ?
                      dev_mem[chip_of4(mem_en) * 256 + int'(mem_addr)] :
                    (mem_we_L == MEM_WR) ? 16'hzzzz : SENTINEL;

  assign mem_data2 = (mem_re_L2 == MEM_RD && mem_en2 != '0) ?
                       {chip_of256(mem_en2) ^ 8'h3C, mem_addr2} :
                     (mem_we_L2 == MEM_WR) ? 16'hzzzz : SENTINEL;

  always @(posedge clock)
    if (mem_we_L == MEM_WR && mem_en != 4'b0)
      dev_mem[chip_of4(mem_en) * 256 + int'(mem_addr)] <= mem_data;

  // Transfer-level model: each command expands into per-word bus transfers.
  typedef struct {
    bit          wr;
    logic [3:0]  en;
    logic [7:0]  addr;
    logic [15:0] data;
  } xfer_t;

  xfer_t       exp_bus[$];
  logic [15:0] exp_rd[$];
  logic        exp_done[$];
  logic [3:0]  obs_en[$];
  logic [7:0]  obs_addr[$];
  logic [15:0] last_rdata = 16'h0;

  function automatic logic [3:0] chip_en(input logic [15:0] a);
    return (a[15:8] < 8'd4) ? (4'b0001 << a[15:8]) : 4'b0000;
  endfunction

  function automatic logic [15:0] word_at(input logic [15:0] wbase, input int k);
    return wbase + 16'(k) * 16'h1111;
  endfunction

  task automatic model_cmd(input bit wr, input logic [15:0] addr, input logic [15:0] wbase,
                           input int nwords, input bit with_done);
    logic e;
    logic [15:0] a;
    logic [3:0] en;
    e = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      a  = addr + 16'(k);
      en = chip_en(a);
      if (en == 4'b0) e = 1'b1;
      if (wr) begin
        exp_bus.push_back('{1'b1, en, a[7:0], word_at(wbase, k)});
        if (en != 4'b0) ref_mem[a[9:0]] = word_at(wbase, k);
      end else begin
        exp_bus.push_back('{1'b0, en, a[7:0], 16'h0});
        exp_rd.push_back((en != 4'b0) ? ref_mem[a[9:0]] : 16'h0000);
      end
    end
    if (with_done) exp_done.push_back(e);
  endtask

  bit    prev_read = 1'b0;
  bit    xr, xw;
  xfer_t x;

  always @(negedge clock) begin
    if (!reset_L) begin
      prev_read = 1'b0;
    end else begin
      xr = (mem_re_L == MEM_RD);
      xw = (mem_we_L == MEM_WR);
      check("rvalid_follows_read", rvalid, prev_read);
      if (rvalid) begin
        if (exp_rd.size() == 0) check("rvalid_unexpected", rvalid, 1'b0);
        else check("rdata", rdata, exp_rd.pop_front());
        last_rdata = rdata;
      end
      check("strobes_exclusive", xr & xw, 1'b0);
      if (xr || xw) begin
        obs_en.push_back(mem_en);
        obs_addr.push_back(mem_addr);
        if (exp_bus.size() == 0) check("bus_unexpected", xr | xw, 1'b0);
        else begin
          x = exp_bus.pop_front();
          check("bus_dir", xw, x.wr);
          check("mem_en", mem_en, x.en);
          check("mem_addr", mem_addr, x.addr);
          if (xw) check("mem_data_wr", mem_data, x.data);
        end
      end else begin
        check("idle_mem_en", mem_en, 4'b0);
        check("idle_bus_released", mem_data, SENTINEL);
      end
      if (done) begin
        if (exp_done.size() == 0) check("done_unexpected", done, 1'b0);
        else check("err_at_done", err, exp_done.pop_front());
      end
      prev_read = xr;
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
  task automatic run_cmd(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                         input logic [15:0] wbase, input int stall);
    int n;
    model_cmd(wr, addr, wbase, int'(len) + 1, 1'b1);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    if (wr) begin
      for (int k = 0; k <= int'(len); k++) begin
        if (k > 0) repeat (stall) begin wvalid = 1'b0; @(posedge clock); #1; end
        wvalid = 1'b1; wdata = word_at(wbase, k);
        @(posedge clock); #1;
      end
      wvalid = 1'b0;
    end
    n = 0;
    while (!done && n < 600) begin @(posedge clock); #1; n++; end
    check("done_within_budget", done, 1'b1);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish before 200000", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = 16'(i) * 16'h0123 ^ 16'hC3C3;
      ref_mem[i] = 16'(i) * 16'h0123 ^ 16'hC3C3;
    end

    #2;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_wready", wready, 1'b0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_en", mem_en, 4'b0);
    check("rst_mem_addr", mem_addr, 8'h0);
    check("rst_we", mem_we_L, MEM_WR_OFF);
    check("rst_re", mem_re_L, MEM_RD_OFF);
    check("rst_bus_released", mem_data, SENTINEL);
    #10 reset_L = 1'b1;
    @(posedge clock); #1;

    // Single-word write then readback.
    obs_en = {}; obs_addr = {};
    run_cmd(1'b1, 16'h0010, 8'd0, 16'hBEEF, 0);
    run_cmd(1'b0, 16'h0010, 8'd0, 16'h0, 0);
    check("t1_obs_count", obs_en.size(), 2);
    check("t1_wr_en", obs_en[0], 4'b0001);
    check("t1_wr_addr", obs_addr[0], 8'h10);
    check("t1_rd_en", obs_en[1], 4'b0001);
    check("t1_readback", last_rdata, 16'hBEEF);
    check("t1_err", err, 1'b0);

    // Read burst across the chip 0 / chip 1 boundary.
    obs_en = {}; obs_addr = {};
    run_cmd(1'b0, 16'h00FE, 8'd3, 16'h0, 0);
    check("t2_obs_count", obs_en.size(), 4);
    check("t2_en0", obs_en[0], 4'b0001);
    check("t2_en1", obs_en[1], 4'b0001);
    check("t2_en2", obs_en[2], 4'b0010);
    check("t2_en3", obs_en[3], 4'b0010);
    check("t2_addr0", obs_addr[0], 8'hFE);
    check("t2_addr1", obs_addr[1], 8'hFF);
    check("t2_addr2", obs_addr[2], 8'h00);
    check("t2_addr3", obs_addr[3], 8'h01);

    // Stalled write burst then readback.
    run_cmd(1'b1, 16'h0120, 8'd2, 16'h7000, 2);
    run_cmd(1'b0, 16'h0120, 8'd2, 16'h0, 0);
    check("t3_last_word", last_rdata, 16'h9222);

    // Unmapped read: zero data, sticky err until the next accept.
    run_cmd(1'b0, 16'h0500, 8'd0, 16'h0, 0);
    check("t4_rdata_zero", last_rdata, 16'h0000);
    check("t4_err_after_done", err, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    check("t4_err_sticky", err, 1'b1);
    run_cmd(1'b0, 16'h0011, 8'd0, 16'h0, 0);
    check("t4_err_cleared", err, 1'b0);

    // 256-chip instance: wrap from 16'hFFFF to 16'h0000.
    cmd_valid2 = 1'b1; cmd_write2 = 1'b0; cmd_addr2 = 16'hFFFF; cmd_len2 = 8'd1;
    @(posedge clock); #1;
    cmd_valid2 = 1'b0;
    @(negedge clock);
    check("t5_en_255", mem_en2, 256'(1) << 255);
    check("t5_addr_ff", mem_addr2, 8'hFF);
    check("t5_re", mem_re_L2, MEM_RD);
    @(negedge clock);
    check("t5_rvalid0", rvalid2, 1'b1);
    check("t5_rdata0", rdata2, 16'hC3FF);
    check("t5_en_0", mem_en2, 256'(1));
    check("t5_addr_00", mem_addr2, 8'h00);
    @(negedge clock);
    check("t5_rvalid1", rvalid2, 1'b1);
    check("t5_rdata1", rdata2, 16'h3C00);
    check("t5_done", done2, 1'b1);
    check("t5_err", err2, 1'b0);
    @(posedge clock); #1;

    // Reset in the middle of a 4-word write: two words land, no done.
    model_cmd(1'b1, 16'h0200, 16'h1234, 2, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0200; cmd_len = 8'd3;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    wvalid = 1'b1; wdata = word_at(16'h1234, 0);
    @(posedge clock); #1;
    wdata = word_at(16'h1234, 1);
    @(posedge clock); #1;
    wdata = word_at(16'h1234, 2);
    #1 reset_L = 1'b0;
    #1;
    check("t6_cmd_ready", cmd_ready, 1'b1);
    check("t6_wready", wready, 1'b0);
    check("t6_rdata", rdata, 16'h0);
    check("t6_rvalid", rvalid, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_err", err, 1'b0);
    check("t6_mem_en", mem_en, 4'b0);
    check("t6_mem_addr", mem_addr, 8'h0);
    check("t6_we", mem_we_L, MEM_WR_OFF);
    check("t6_bus_released", mem_data, SENTINEL);
    wvalid = 1'b0;
    @(negedge clock);
    check("t6_done_held_low", done, 1'b0);
    #2 reset_L = 1'b1;
    @(posedge clock); #1;
    run_cmd(1'b0, 16'h0200, 8'd2, 16'h0, 0);
    check("t6_second_word", dev_mem[10'h201], 16'h2345);

    repeat (2) @(posedge clock);
    #1;
    check("left_bus_expect", exp_bus.size(), 0);
    check("left_rd_expect", exp_rd.size(), 0);
    check("left_done_expect", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
